// File: rtl/gerenciador_entrada_pkg.sv
// pacote_es: shared state encoding and word constants for the stdin path
package pacote_es;
    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        ESPERA_PRESS = 2'd1,
        PRONTO       = 2'd2,
        ESPERA_SOLTA = 2'd3
    } estado_t;
    localparam int LARG_PALAVRA = 32;
    localparam logic [7:0] CONTAGEM_MAX_LEITURAS = 8'hFF;
endpackage

// File: rtl/gerenciador_entrada_debouncer.sv
// debouncer_botao: 2-FF synchronizer, level debouncer and press-edge pulse for an active-low key
module debouncer_botao #(
    parameter int DEBOUNCE_CICLOS = 1000000
) (
    input  logic clk_rapido,
    input  logic reset,
    input  logic botao,
    output logic nivel,
    output logic pressao
);
    localparam int LARG_CONT = $clog2(DEBOUNCE_CICLOS);
    localparam logic [LARG_CONT-1:0] CONT_FIM = LARG_CONT'(DEBOUNCE_CICLOS - 1);
    logic [1:0] sinc;
    logic btn_s;
    logic [LARG_CONT-1:0] cont;
    assign btn_s = ~sinc[1];
    // the counter only runs while the synchronized key disagrees with the accepted level
    always_ff @(posedge clk_rapido) begin
        if (!reset) begin
            sinc    <= 2'b11;
            cont    <= '0;
            nivel   <= 1'b0;
            pressao <= 1'b0;
        end else begin
            sinc    <= {sinc[0], botao};
            pressao <= 1'b0;
            if (btn_s == nivel)
                cont <= '0;
            else if (cont == CONT_FIM) begin
                cont    <= '0;
                nivel   <= btn_s;
                pressao <= btn_s;
            end else
                cont <= cont + 1'b1;
        end
    end
endmodule

// File: rtl/gerenciador_entrada.sv
// gerenciador_entrada: stalls the processor on SwToReg until a debounced key press captures the switches
module gerenciador_entrada
    import pacote_es::*;
#(
    parameter int LARG_SW         = 10,
    parameter int DEBOUNCE_CICLOS = 1000000,
    parameter bit EXT_SINAL       = 1'b0
) (
    input  logic                    clk_rapido,
    input  logic                    reset,
    input  logic [LARG_SW-1:0]      sw,
    input  logic                    botao,
    input  logic                    SwToReg,
    input  logic                    avanco,
    output logic                    stall,
    output logic [LARG_PALAVRA-1:0] dado_stdin,
    output logic                    valido,
    output logic                    aguardando,
    output logic [7:0]              n_leituras
);
    estado_t estado, estado_prox;
    logic btn_d, pressao, captura, consumo;
    logic [LARG_PALAVRA-1:0] sw_ext;
    debouncer_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_debouncer (
        .clk_rapido(clk_rapido),
        .reset(reset),
        .botao(botao),
        .nivel(btn_d),
        .pressao(pressao)
    );
    assign sw_ext = EXT_SINAL ? {{(LARG_PALAVRA-LARG_SW){sw[LARG_SW-1]}}, sw}
                              : {{(LARG_PALAVRA-LARG_SW){1'b0}}, sw};
    // combinational so the very first SwToReg cycle already holds the PC
    assign stall      = SwToReg & (estado != PRONTO);
    assign valido     = estado == PRONTO;
    assign aguardando = estado == ESPERA_PRESS;
    always_comb begin
        estado_prox = estado;
        captura     = 1'b0;
        consumo     = 1'b0;
        case (estado)
            OCIOSO:       if (SwToReg) estado_prox = btn_d ? ESPERA_SOLTA : ESPERA_PRESS;
            ESPERA_SOLTA: if (!btn_d) estado_prox = ESPERA_PRESS;
            ESPERA_PRESS: begin
                if (!SwToReg)
                    estado_prox = OCIOSO;
                else if (pressao) begin
                    estado_prox = PRONTO;
                    captura     = 1'b1;
                end
            end
            PRONTO: begin
                if (avanco) begin
                    estado_prox = btn_d ? ESPERA_SOLTA : OCIOSO;
                    consumo     = 1'b1;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end
    always_ff @(posedge clk_rapido) begin
        if (!reset) begin
            estado     <= OCIOSO;
            dado_stdin <= '0;
            n_leituras <= '0;
        end else begin
            estado <= estado_prox;
            if (captura)
                dado_stdin <= sw_ext;
            if (consumo)
                n_leituras <= (n_leituras == CONTAGEM_MAX_LEITURAS) ? 8'd0 : n_leituras + 1'b1;
        end
    end
endmodule

// File: tb/tb_gerenciador_entrada.sv
// tb_gerenciador_entrada: directed checks of the stdin manager with a short debounce window
module tb_gerenciador_entrada;
    logic clk = 1'b0;
    logic reset, botao, SwToReg, avanco;
    logic [9:0] sw;
    logic stall, valido, aguardando, stall_s, valido_s, aguardando_s;
    logic [31:0] dado, dado_s;
    logic [7:0] n_leit, n_leit_s;
    int n_testes = 0;
    int n_falhas = 0;

    always #5 clk = ~clk;

    gerenciador_entrada #(.LARG_SW(10), .DEBOUNCE_CICLOS(4), .EXT_SINAL(1'b0)) dut (
        .clk_rapido(clk), .reset(reset), .sw(sw), .botao(botao), .SwToReg(SwToReg),
        .avanco(avanco), .stall(stall), .dado_stdin(dado), .valido(valido),
        .aguardando(aguardando), .n_leituras(n_leit)
    );
    gerenciador_entrada #(.LARG_SW(10), .DEBOUNCE_CICLOS(4), .EXT_SINAL(1'b1)) dut_s (
        .clk_rapido(clk), .reset(reset), .sw(sw), .botao(botao), .SwToReg(SwToReg),
        .avanco(avanco), .stall(stall_s), .dado_stdin(dado_s), .valido(valido_s),
        .aguardando(aguardando_s), .n_leituras(n_leit_s)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic avancar();
        avanco = 1'b1;
        tick(1);
        avanco = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; SwToReg = 1'b1; botao = 1'b1; avanco = 1'b0; sw = '0;
        tick(3);
        n_testes++; if (stall !== 1'b1) begin n_falhas++; $display("FAIL reset_stall got %b exp 1", stall); end
        n_testes++; if (valido !== 1'b0) begin n_falhas++; $display("FAIL reset_valido got %b exp 0", valido); end
        n_testes++; if (dado !== 32'h0) begin n_falhas++; $display("FAIL reset_dado got %h exp 0", dado); end
        n_testes++; if (n_leit !== 8'd0) begin n_falhas++; $display("FAIL reset_n got %0d exp 0", n_leit); end
        n_testes++; if (aguardando !== 1'b0) begin n_falhas++; $display("FAIL reset_aguardando got %b exp 0", aguardando); end
        reset = 1'b1;
        tick(1);
        n_testes++; if (aguardando !== 1'b1) begin n_falhas++; $display("FAIL release_aguardando got %b exp 1", aguardando); end
        n_testes++; if (stall !== 1'b1) begin n_falhas++; $display("FAIL release_stall got %b exp 1", stall); end
    endtask

    task automatic test_clean_read();
        sw = 10'h2A5; botao = 1'b0;
        tick(6);
        n_testes++; if (valido !== 1'b0) begin n_falhas++; $display("FAIL clean_early_valido got %b exp 0", valido); end
        tick(1);
        n_testes++; if (valido !== 1'b1) begin n_falhas++; $display("FAIL clean_valido got %b exp 1", valido); end
        n_testes++; if (stall !== 1'b0) begin n_falhas++; $display("FAIL clean_stall got %b exp 0", stall); end
        n_testes++; if (dado !== 32'h000002A5) begin n_falhas++; $display("FAIL clean_dado got %h exp 000002a5", dado); end
        n_testes++; if (dado_s !== 32'hFFFFFEA5) begin n_falhas++; $display("FAIL clean_dado_sext got %h exp fffffea5", dado_s); end
        tick(3);
        botao = 1'b1;
        tick(8);
        avancar();
        n_testes++; if (valido !== 1'b0) begin n_falhas++; $display("FAIL clean_consumed got %b exp 0", valido); end
        n_testes++; if (n_leit !== 8'd1) begin n_falhas++; $display("FAIL clean_n got %0d exp 1", n_leit); end
        n_testes++; if (stall !== 1'b1) begin n_falhas++; $display("FAIL clean_rearm_stall got %b exp 1", stall); end
        tick(1);
    endtask

    task automatic test_bounce();
        avancar();
        n_testes++; if (n_leit !== 8'd1) begin n_falhas++; $display("FAIL stray_avanco_n got %0d exp 1", n_leit); end
        sw = 10'h155;
        for (int i = 0; i < 10; i++) begin
            botao = i[0];
            tick(2);
            n_testes++; if (stall !== 1'b1) begin n_falhas++; $display("FAIL bounce_stall[%0d] got %b exp 1", i, stall); end
        end
        n_testes++; if (valido !== 1'b0) begin n_falhas++; $display("FAIL bounce_valido got %b exp 0", valido); end
        botao = 1'b0;
        tick(6);
        botao = 1'b1;
        tick(1);
        n_testes++; if (valido !== 1'b1) begin n_falhas++; $display("FAIL bounce_capture got %b exp 1", valido); end
        n_testes++; if (dado !== 32'h00000155) begin n_falhas++; $display("FAIL bounce_dado got %h exp 00000155", dado); end
        tick(7);
        avancar();
        n_testes++; if (n_leit !== 8'd2) begin n_falhas++; $display("FAIL bounce_n got %0d exp 2", n_leit); end
        tick(1);
    endtask

    task automatic test_sign_ext();
        sw = 10'h3FF; botao = 1'b0;
        tick(10);
        botao = 1'b1;
        n_testes++; if (dado_s !== 32'hFFFFFFFF) begin n_falhas++; $display("FAIL sext_dado got %h exp ffffffff", dado_s); end
        n_testes++; if (dado !== 32'h000003FF) begin n_falhas++; $display("FAIL zext_dado got %h exp 000003ff", dado); end
        tick(7);
        avancar();
        n_testes++; if (n_leit !== 8'd3) begin n_falhas++; $display("FAIL sext_n got %0d exp 3", n_leit); end
        tick(1);
    endtask

    task automatic test_back_to_back();
        sw = 10'h0AA; botao = 1'b0;
        tick(8);
        n_testes++; if (dado !== 32'h000000AA) begin n_falhas++; $display("FAIL held_dado got %h exp 000000aa", dado); end
        avancar();
        n_testes++; if (n_leit !== 8'd4) begin n_falhas++; $display("FAIL held_n got %0d exp 4", n_leit); end
        n_testes++; if (stall !== 1'b1) begin n_falhas++; $display("FAIL held_stall got %b exp 1", stall); end
        n_testes++; if (aguardando !== 1'b0) begin n_falhas++; $display("FAIL held_aguardando got %b exp 0", aguardando); end
        tick(10);
        n_testes++; if (valido !== 1'b0) begin n_falhas++; $display("FAIL held_no_recapture got %b exp 0", valido); end
        n_testes++; if (stall !== 1'b1) begin n_falhas++; $display("FAIL held_stall_late got %b exp 1", stall); end
        botao = 1'b1;
        tick(7);
        n_testes++; if (aguardando !== 1'b1) begin n_falhas++; $display("FAIL released_aguardando got %b exp 1", aguardando); end
        sw = 10'h005; botao = 1'b0;
        tick(7);
        botao = 1'b1;
        n_testes++; if (dado !== 32'h00000005) begin n_falhas++; $display("FAIL second_dado got %h exp 00000005", dado); end
        n_testes++; if (valido !== 1'b1) begin n_falhas++; $display("FAIL second_valido got %b exp 1", valido); end
        tick(7);
        avancar();
        n_testes++; if (n_leit !== 8'd5) begin n_falhas++; $display("FAIL second_n got %0d exp 5", n_leit); end
        tick(1);
    endtask

    task automatic test_mid_reset();
        sw = 10'h123; botao = 1'b0;
        tick(7);
        botao = 1'b1;
        n_testes++; if (valido !== 1'b1) begin n_falhas++; $display("FAIL pre_reset_valido got %b exp 1", valido); end
        reset = 1'b0;
        tick(1);
        n_testes++; if (valido !== 1'b0) begin n_falhas++; $display("FAIL mid_reset_valido got %b exp 0", valido); end
        n_testes++; if (dado !== 32'h0) begin n_falhas++; $display("FAIL mid_reset_dado got %h exp 0", dado); end
        n_testes++; if (n_leit !== 8'd0) begin n_falhas++; $display("FAIL mid_reset_n got %0d exp 0", n_leit); end
        n_testes++; if (stall !== 1'b1) begin n_falhas++; $display("FAIL mid_reset_stall got %b exp 1", stall); end
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            sw = 10'(i); botao = 1'b0;
            tick(7);
            botao = 1'b1;
            n_testes++; if (valido !== 1'b1) begin n_falhas++; $display("FAIL wrap_valido[%0d] got %b exp 1", i, valido); end
            tick(7);
            avancar();
            if (i == 254) begin
                n_testes++; if (n_leit !== 8'd255) begin n_falhas++; $display("FAIL wrap_n255 got %0d exp 255", n_leit); end
            end
            tick(1);
        end
        n_testes++; if (n_leit !== 8'd0) begin n_falhas++; $display("FAIL wrap_n0 got %0d exp 0", n_leit); end
        n_testes++; if (dado !== 32'h000000FF) begin n_falhas++; $display("FAIL wrap_dado_hold got %h exp 000000ff", dado); end
    endtask

    initial begin
        test_reset();
        test_clean_read();
        test_bounce();
        test_sign_ext();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end
endmodule
